// File: rtl/instr_axi_read_master_if.sv
// rtl/instr_axi_read_master_if.sv - fetch-side bus bundle: PC input, AXI-lite AR/R channels, decode handshake
interface instr_axi_read_master_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  instr_addr;
  logic                   flush;
  logic [ADDR_WIDTH-1:0]  ARADDR;
  logic [2:0]             ARPROT;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [INSTR_WIDTH-1:0] RDATA;
  logic [1:0]             RRESP;
  logic                   RVALID;
  logic                   RREADY;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_fault;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    input  instr_addr, flush, ARREADY, RDATA, RRESP, RVALID, instr_ready,
    output ARADDR, ARPROT, ARVALID, RREADY, instr_out, instr_pc, instr_fault, instr_valid
  );

  modport slave (
    output instr_addr, flush, ARREADY, RDATA, RRESP, RVALID, instr_ready,
    input  ARADDR, ARPROT, ARVALID, RREADY, instr_out, instr_pc, instr_fault, instr_valid
  );
endinterface

// File: rtl/instr_axi_read_master.sv
// rtl/instr_axi_read_master.sv - AXI-lite instruction fetch master with instruction FIFO and flush
// Optional macro FETCH_RRESP_CHECK_EN: keep RRESP[1] per entry and present it as instr_fault.
module instr_axi_read_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  instr_axi_read_master_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  araddr;
  logic                   arvalid;
  logic                   rready;
  logic                   discard;
  logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic                   r_hs;
  logic                   push;
  logic                   pop;

`ifdef FETCH_RRESP_CHECK_EN
  logic                   fault_mem [FIFO_DEPTH];
  assign bus.instr_fault = fault_mem[rd_ptr];
`else
  assign bus.instr_fault = 1'b0;
`endif

  assign r_hs = (state == DATA) && rready && bus.RVALID;
  // A response that lands under discard or alongside a flush belongs to the old stream
  assign push = r_hs && !discard && !bus.flush;
  assign pop  = (count != '0) && bus.instr_ready && !bus.flush;

  assign bus.ARADDR      = araddr;
  assign bus.ARPROT      = 3'b100;
  assign bus.ARVALID     = arvalid;
  assign bus.RREADY      = rready;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_out   = instr_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      discard <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
`ifdef FETCH_RRESP_CHECK_EN
        fault_mem[i] <= 1'b0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          // With at most one read outstanding, a free slot now is a free slot at push time
          if ((count < DEPTH_C) && !bus.flush) begin
            araddr  <= bus.instr_addr;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.flush) discard <= 1'b1;
          if (bus.ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bus.RVALID) begin
            rready  <= 1'b0;
            discard <= 1'b0;
            state   <= IDLE;
          end else if (bus.flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= araddr;
          instr_mem[wr_ptr] <= bus.RDATA;
`ifdef FETCH_RRESP_CHECK_EN
          fault_mem[wr_ptr] <= bus.RRESP[1];
`endif
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_axi_read_master.sv
// tb/tb_instr_axi_read_master.sv - randomized bench with queue model of the fetch stream
// Honours FETCH_RRESP_CHECK_EN for the expected instr_fault value.
module tb_instr_axi_read_master;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_axi_read_master_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus();
  instr_axi_read_master #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          fault;
  } entry_t;

  entry_t        q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  int            ar_max = 0, r_max = 0, ready_pct = 100, flush_pct = 0, ar_fixed = -1;
  bit            rand_resp = 0, flush_once = 0;
  logic [AW-1:0] flush_target = '0, pc = '0;
  logic [AW-1:0] ar_log[$], stale_log[$];
  int            ar_cyc[$];
  bit            seen_pc20 = 0;
  logic          seen_pc20_fault = 1'b0;

  bit            in_rst_prev = 1, hold_ar = 0, exp_valid = 0, exp_issue = 0;
  bit            prev_ar_hs = 0, prev_r_hs = 0, taint = 0;
  logic [AW-1:0] prev_araddr = '0, exp_addr = '0;
  bit            ar_active = 0, pend_r = 0;
  int            ar_wait = 0, r_wait = 0;
  logic [AW-1:0] r_addr = '0;
  logic [1:0]    r_resp = '0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic exp_fault(input logic [1:0] resp);
`ifdef FETCH_RRESP_CHECK_EN
    return resp[1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: got no event, required one within the cycle budget", name, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Compare, then drive the next cycle's inputs, then advance the model to the coming edge
  always @(negedge clk) begin
    bit     ar_hs, r_hs, pop, advance, fo;
    entry_t e;
    cyc++;
    if (in_rst_prev) begin
      chk("rst_arvalid", bus.ARVALID, 0);
      chk("rst_rready", bus.RREADY, 0);
      chk("rst_araddr", bus.ARADDR, 0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr_out", bus.instr_out, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
      chk("rst_instr_fault", bus.instr_fault, 0);
    end else begin
      chk("instr_valid", bus.instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("instr_pc", bus.instr_pc, q[0].pc);
        chk("instr_out", bus.instr_out, q[0].instr);
        chk("instr_fault", bus.instr_fault, q[0].fault);
      end
      chk("arprot", bus.ARPROT, 3'b100);
      if (hold_ar) begin
        chk("ar_hold_valid", bus.ARVALID, 1);
        chk("ar_hold_addr", bus.ARADDR, prev_araddr);
      end
      if (exp_valid) begin
        chk("ar_issue", bus.ARVALID, exp_issue);
        if (exp_issue) chk("ar_issue_addr", bus.ARADDR, exp_addr);
      end
      if (prev_ar_hs) begin
        chk("rready_after_ar", bus.RREADY, 1);
        chk("arvalid_after_ar", bus.ARVALID, 0);
      end
      if (prev_r_hs) begin
        chk("rready_after_r", bus.RREADY, 0);
        chk("arvalid_after_r", bus.ARVALID, 0);
      end
    end

    fo = flush_once;
    flush_once = 0;
    bus.instr_ready = ($urandom_range(0, 99) < ready_pct);
    bus.flush = fo || ($urandom_range(0, 99) < flush_pct);
    bus.instr_addr = pc;
    if (bus.ARVALID) begin
      if (!ar_active) begin
        ar_active = 1;
        ar_wait = (ar_fixed >= 0) ? ar_fixed : int'($urandom_range(0, ar_max));
      end
      bus.ARREADY = (ar_wait == 0);
      if (ar_wait != 0) ar_wait--;
    end else begin
      bus.ARREADY = 1'b0;
    end
    if (pend_r) begin
      bus.RVALID = (r_wait == 0);
      if (r_wait != 0) r_wait--;
      bus.RDATA = mem_word(r_addr);
      bus.RRESP = r_resp;
    end else begin
      bus.RVALID = 1'b0;
      bus.RDATA = $urandom;
      bus.RRESP = 2'($urandom);
    end

    if (!rst) begin
      q.delete();
      taint = 0; ar_active = 0; pend_r = 0; in_rst_prev = 1;
      hold_ar = 0; exp_valid = 0; prev_ar_hs = 0; prev_r_hs = 0;
    end else begin
      in_rst_prev = 0;
      ar_hs = bus.ARVALID && bus.ARREADY;
      r_hs = bus.RVALID && bus.RREADY;
      pop = (q.size() != 0) && bus.instr_ready && !bus.flush;
      advance = ar_hs && !taint && !bus.flush;
      exp_valid = !bus.ARVALID && !bus.RREADY;
      exp_issue = exp_valid && (q.size() < DEPTH) && !bus.flush;
      exp_addr = bus.instr_addr;
      hold_ar = bus.ARVALID && !bus.ARREADY;
      prev_araddr = bus.ARADDR;
      prev_ar_hs = ar_hs;
      prev_r_hs = r_hs;
      if (ar_hs) begin
        if (advance) begin
          ar_log.push_back(bus.ARADDR);
          ar_cyc.push_back(cyc);
        end else begin
          stale_log.push_back(bus.ARADDR);
        end
        ar_active = 0;
        pend_r = 1;
        r_addr = bus.ARADDR;
        r_wait = int'($urandom_range(0, r_max));
        r_resp = (rand_resp ? 2'($urandom) : 2'b00) | ((bus.ARADDR == 32'h20) ? 2'b10 : 2'b00);
      end
      if (pop && q[0].pc == 32'h20) begin
        seen_pc20 = 1;
        seen_pc20_fault = bus.instr_fault;
      end
      if (bus.flush) begin
        q.delete();
        taint = (bus.ARVALID || bus.RREADY) && !r_hs;
      end else begin
        if (pop) void'(q.pop_front());
        if (r_hs) begin
          if (!taint) begin
            e.pc = r_addr;
            e.instr = mem_word(r_addr);
            e.fault = exp_fault(r_resp);
            q.push_back(e);
          end
          taint = 0;
        end
      end
      if (r_hs) pend_r = 0;
      if (bus.flush) pc = fo ? flush_target : {22'd0, 8'($urandom), 2'b00};
      else if (advance) pc = pc + 4;
    end
  end

  initial begin
    bit            found;
    logic          pv;
    logic [AW-1:0] addr_before;
    bus.flush = 0; bus.instr_ready = 0; bus.instr_addr = '0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = '0;

    rst = 0;
    step(3);
    chk("t1_arvalid", bus.ARVALID, 0);
    chk("t1_rready", bus.RREADY, 0);
    chk("t1_instr_valid", bus.instr_valid, 0);

    pc = '0;
    rst = 1;
    step(12);
    if (ar_log.size() >= 3) begin
      chk("t2_addr0", ar_log[0], 32'h0);
      chk("t2_addr1", ar_log[1], 32'h4);
      chk("t2_addr2", ar_log[2], 32'h8);
      chk("t2_spacing01", ar_cyc[1] - ar_cyc[0], 3);
      chk("t2_spacing12", ar_cyc[2] - ar_cyc[1], 3);
    end else timeout("t2_fetches");

    ready_pct = 0; flush_once = 1; flush_target = 32'h40; ar_log.delete();
    step(40);
    chk("t3_reads", ar_log.size(), 4);
    chk("t3_arvalid_idle", bus.ARVALID, 0);
    chk("t3_instr_valid", bus.instr_valid, 1);
    chk("t3_head_pc", bus.instr_pc, 32'h40);
    ready_pct = 100;
    step(30);
    if (ar_log.size() >= 5) chk("t3_resume_addr", ar_log[4], 32'h50);
    else timeout("t3_resume");

    ready_pct = 0; flush_once = 1; flush_target = 32'h80;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (q.size() == 3) found = 1;
    end
    if (found) begin
      flush_once = 1; flush_target = 32'hC0; ar_log.delete();
      step(1);
      chk("t5_instr_valid", bus.instr_valid, 0);
      ready_pct = 100;
      step(15);
      if (ar_log.size() >= 1) chk("t5_refetch", ar_log[0], 32'hC0);
      else timeout("t5_refetch");
    end else timeout("t5_fill");

    ar_fixed = 5;
    found = 0;
    pv = bus.ARVALID;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (bus.ARVALID && !pv) found = 1;
      pv = bus.ARVALID;
    end
    if (found) begin
      addr_before = bus.ARADDR;
      flush_once = 1; flush_target = 32'h100; ar_log.delete(); stale_log.delete();
      for (int i = 0; i < 60 && ar_log.size() == 0; i++) step(1);
      if (ar_log.size() >= 1) chk("t4_redirect", ar_log[0], 32'h100);
      else timeout("t4_redirect");
      if (stale_log.size() >= 1) chk("t4_stale_addr", stale_log[0], addr_before);
      else timeout("t4_stale");
    end else timeout("t4_issue");
    ar_fixed = -1;

    seen_pc20 = 0; flush_once = 1; flush_target = 32'h18;
    for (int i = 0; i < 100 && !seen_pc20; i++) step(1);
    if (seen_pc20) begin
`ifdef FETCH_RRESP_CHECK_EN
      chk("t6_fault", seen_pc20_fault, 1);
`else
      chk("t6_fault", seen_pc20_fault, 0);
`endif
    end else timeout("t6_pc20");

    ar_max = 3; r_max = 3; ready_pct = 60; flush_pct = 4; rand_resp = 1;
    step(1500);
    rst = 0;
    step(2);
    rst = 1;
    step(1500);
    flush_pct = 0; ready_pct = 100;
    step(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
